// File: rtl/bsg_mesh_age_sched_if.sv
// Handshake bundle between one mesh output port and its requesting inputs.
// The master side presents the per-input requests, timestamps and lengths.
// The slave side (the scheduler) returns grants and lock/starvation status.
interface bsg_mesh_age_sched_if #(
    parameter int inputs_p    = 4,
    parameter int ts_width_p  = 8,
    parameter int len_width_p = 4
);
    localparam int OWNER_W = $clog2(inputs_p);

    logic                                   ready_i;
    logic [inputs_p-1:0]                    reqs_i;
    logic [inputs_p-1:0][ts_width_p-1:0]    ts_i;
    logic [inputs_p-1:0][len_width_p-1:0]   len_i;
    logic [inputs_p-1:0]                    grants_o;
    logic                                   locked_o;
    logic [OWNER_W-1:0]                     owner_o;
    logic [inputs_p-1:0]                    starved_o;

    modport master (
        output ready_i, reqs_i, ts_i, len_i,
        input  grants_o, locked_o, owner_o, starved_o
    );

    modport slave (
        input  ready_i, reqs_i, ts_i, len_i,
        output grants_o, locked_o, owner_o, starved_o
    );
endinterface

// File: rtl/bsg_mesh_age_sched.sv
// Per-output-port age-based scheduler for the mesh router crossbar.
// Oldest timestamp wins (modular comparison), ties go round-robin, starved
// inputs override age, and a granted multi-flit packet locks the output to
// its input until the last body flit has been transferred.
module bsg_mesh_age_sched #(
    parameter int inputs_p       = 4,
    parameter int ts_width_p     = 8,
    parameter int len_width_p    = 4,
    parameter int starve_limit_p = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bsg_mesh_age_sched_if.slave  sched_if
);
    localparam int IDX_W = $clog2(inputs_p);
    localparam int CNT_W = $clog2(starve_limit_p + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(starve_limit_p);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [len_width_p-1:0] remaining_q, remaining_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       wait_cnt_q [inputs_p];
    logic [CNT_W-1:0]       wait_cnt_d [inputs_p];

    logic [inputs_p-1:0]    starved;
    logic [inputs_p-1:0]    younger;
    logic [inputs_p-1:0]    cand;
    logic [IDX_W-1:0]       win_idx;
    logic [inputs_p-1:0]    grants_raw;
    logic [inputs_p-1:0]    grants;

    // a is older than b when b-a (mod 2^w) lies strictly inside the lower half;
    // a difference of exactly half the range counts as a tie.
    function automatic logic is_older(input logic [ts_width_p-1:0] a,
                                      input logic [ts_width_p-1:0] b);
        logic [ts_width_p-1:0] diff;
        diff = b - a;
        return (diff != '0) && !diff[ts_width_p-1];
    endfunction

    // Starvation flags straight from the saturating wait counters.
    always_comb begin
        for (int i = 0; i < inputs_p; i++) begin
            starved[i] = (wait_cnt_q[i] == STARVE_MAX);
        end
    end

    // Candidate set: starved requesters first, otherwise the oldest requesters.
    // Modular age is not transitive, so a cyclic set of timestamps can leave no
    // oldest requester; all requesters are then candidates so the output never
    // stalls while work is pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would infer a latch.
        younger = '0;
        cand    = '0;
        for (int i = 0; i < inputs_p; i++) begin
            for (int j = 0; j < inputs_p; j++) begin
                if (j != i && sched_if.reqs_i[j] &&
                    is_older(sched_if.ts_i[j], sched_if.ts_i[i])) begin
                    younger[i] = 1'b1;
                end
            end
        end
        if (|(sched_if.reqs_i & starved)) begin
            cand = sched_if.reqs_i & starved;
        end else if (|(sched_if.reqs_i & ~younger)) begin
            cand = sched_if.reqs_i & ~younger;
        end else begin
            cand = sched_if.reqs_i;
        end
    end

    // Round-robin pick: first candidate at or after rr_ptr, with wrap-around.
    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < inputs_p; k++) begin
            idx = (int'(rr_ptr_q) + k) % inputs_p;
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    // FSM state, lock bookkeeping and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            remaining_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value regardless of statement order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // FSM next state and raw grants: header arbitration in IDLE, owner-only in LOCKED.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        grants_raw  = '0;
        case (state_q)
            ST_IDLE: begin
                if (sched_if.ready_i && |sched_if.reqs_i) begin
                    grants_raw[win_idx] = 1'b1;
                    rr_ptr_d = (int'(win_idx) == inputs_p - 1) ? '0
                                                               : win_idx + IDX_W'(1);
                    if (sched_if.len_i[win_idx] != '0) begin
                        state_d     = ST_LOCKED;
                        owner_d     = win_idx;
                        remaining_d = sched_if.len_i[win_idx];
                    end
                end
            end
            ST_LOCKED: begin
                // A missing body flit is a bubble; the lock is never released early.
                if (sched_if.ready_i && sched_if.reqs_i[owner_q]) begin
                    grants_raw[owner_q] = 1'b1;
                    remaining_d         = remaining_q - len_width_p'(1);
                    if (remaining_q == len_width_p'(1)) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grants are suppressed for as long as reset is held, independent of the clock.
    assign grants = reset_n_i ? grants_raw : '0;

    // Wait counters: clear when idle or served, count cycles lost while the output was ready.
    always_comb begin
        for (int i = 0; i < inputs_p; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!sched_if.reqs_i[i] || grants[i]) begin
                wait_cnt_d[i] = '0;
            end else if (sched_if.ready_i && wait_cnt_q[i] != STARVE_MAX) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: this array is a bank of flops, not a RAM, so every entry is
            // reset; stale counts would otherwise grant a bogus starvation override.
            for (int i = 0; i < inputs_p; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < inputs_p; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign sched_if.grants_o  = grants;
    assign sched_if.locked_o  = (state_q == ST_LOCKED);
    assign sched_if.owner_o   = (state_q == ST_LOCKED) ? owner_q : '0;
    assign sched_if.starved_o = starved;
endmodule

// File: tb/tb_bsg_mesh_age_sched.sv
// Directed bench for bsg_mesh_age_sched: a table of single-cycle vectors with
// hand-computed expectations, plus a hand-written asynchronous mid-lock reset.
module tb_bsg_mesh_age_sched;
    localparam int N  = 4;
    localparam int TW = 8;
    localparam int LW = 4;

    typedef struct {
        string               name;
        bit                  do_rst;
        int                  reps;
        logic                ready;
        logic [N-1:0]        reqs;
        logic [N-1:0][TW-1:0] ts;
        logic [N-1:0][LW-1:0] len;
        logic [N-1:0]        exp_grants;
        logic                exp_locked;
        logic [1:0]          exp_owner;
        logic [N-1:0]        exp_starved;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    vec_t vecs[$];

    bsg_mesh_age_sched_if #(.inputs_p(N), .ts_width_p(TW), .len_width_p(LW)) sif ();

    bsg_mesh_age_sched #(
        .inputs_p      (N),
        .ts_width_p    (TW),
        .len_width_p   (LW),
        .starve_limit_p(3)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .sched_if (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit rst, input int reps,
                                input logic rdy, input logic [3:0] reqs,
                                input logic [31:0] ts, input logic [15:0] len,
                                input logic [3:0] eg, input logic el,
                                input logic [1:0] eo, input logic [3:0] es);
        vec_t v;
        v.name = name;  v.do_rst = rst;  v.reps = reps;
        v.ready = rdy;  v.reqs = reqs;   v.ts = ts;  v.len = len;
        v.exp_grants = eg;  v.exp_locked = el;
        v.exp_owner = eo;   v.exp_starved = es;
        return v;
    endfunction

    task automatic drive(input logic rdy, input logic [3:0] reqs,
                         input logic [31:0] ts, input logic [15:0] len);
        sif.ready_i = rdy;
        sif.reqs_i  = reqs;
        sif.ts_i    = ts;
        sif.len_i   = len;
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic check_outputs(input string name, input logic [3:0] eg, input logic el,
                                 input logic [1:0] eo, input logic [3:0] es);
        check({name, " grants"},  32'(sif.grants_o),  32'(eg));
        check({name, " locked"},  32'(sif.locked_o),  32'(el));
        check({name, " owner"},   32'(sif.owner_o),   32'(eo));
        check({name, " starved"}, 32'(sif.starved_o), 32'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // name rst reps ready reqs ts{3,2,1,0} len{3,2,1,0} | grants locked owner starved
        // Age, wrap-around and tie handling (rr_ptr tracked by hand).
        vecs.push_back(mk("reset_idle",  1, 1, 1, 4'b0000, 32'h00000000, 16'h0000, 4'b0000, 0, 0, 4'b0000));
        vecs.push_back(mk("age_win",     0, 1, 1, 4'b0110, 32'h00051000, 16'h0000, 4'b0100, 0, 0, 4'b0000));
        vecs.push_back(mk("rr_is_3",     0, 1, 1, 4'b1001, 32'h00000000, 16'h0000, 4'b1000, 0, 0, 4'b0000));
        vecs.push_back(mk("wrap_fe_3",   0, 1, 1, 4'b1001, 32'hFE000002, 16'h0000, 4'b1000, 0, 0, 4'b0000));
        vecs.push_back(mk("solo_0",      0, 1, 1, 4'b0001, 32'h00000000, 16'h0000, 4'b0001, 0, 0, 4'b0000));
        vecs.push_back(mk("wrap_fe_0",   0, 1, 1, 4'b1001, 32'h020000FE, 16'h0000, 4'b0001, 0, 0, 4'b0000));
        vecs.push_back(mk("tie_rr1",     0, 1, 1, 4'b1001, 32'h00000000, 16'h0000, 4'b1000, 0, 0, 4'b0000));
        vecs.push_back(mk("move_rr",     0, 1, 1, 4'b0100, 32'h00000000, 16'h0000, 4'b0100, 0, 0, 4'b0000));
        vecs.push_back(mk("half_tie",    0, 1, 1, 4'b1001, 32'h80000000, 16'h0000, 4'b1000, 0, 0, 4'b0000));
        // Lock: input 2 header (len 3) then input 0 older and requesting throughout.
        vecs.push_back(mk("lock_hdr",    1, 1, 1, 4'b0100, 32'h00000000, 16'h0300, 4'b0100, 0, 0, 4'b0000));
        vecs.push_back(mk("lock_body",   0, 3, 1, 4'b0101, 32'h00050001, 16'h0300, 4'b0100, 1, 2, 4'b0000));
        vecs.push_back(mk("lock_exit",   0, 1, 1, 4'b0101, 32'h00050001, 16'h0300, 4'b0001, 0, 0, 4'b0001));
        // Lock with a bubble: owner drops its request for one body cycle.
        vecs.push_back(mk("bub_hdr",     1, 1, 1, 4'b0100, 32'h00000000, 16'h0200, 4'b0100, 0, 0, 4'b0000));
        vecs.push_back(mk("bub_gap",     0, 1, 1, 4'b0001, 32'h00050001, 16'h0200, 4'b0000, 1, 2, 4'b0000));
        vecs.push_back(mk("bub_body",    0, 2, 1, 4'b0101, 32'h00050001, 16'h0200, 4'b0100, 1, 2, 4'b0000));
        vecs.push_back(mk("bub_exit",    0, 1, 1, 4'b0101, 32'h00050001, 16'h0200, 4'b0001, 0, 0, 4'b0001));
        // Starvation: input 1 always younger than input 0.
        vecs.push_back(mk("st_first",    1, 1, 1, 4'b0011, 32'h00001000, 16'h0000, 4'b0001, 0, 0, 4'b0000));
        vecs.push_back(mk("st_lose",     0, 2, 1, 4'b0011, 32'h00001000, 16'h0000, 4'b0001, 0, 0, 4'b0000));
        vecs.push_back(mk("st_win",      0, 1, 1, 4'b0011, 32'h00001000, 16'h0000, 4'b0010, 0, 0, 4'b0010));
        vecs.push_back(mk("st_clear",    0, 1, 1, 4'b0011, 32'h00001000, 16'h0000, 4'b0001, 0, 0, 4'b0000));
        // Backpressure: counters must hold while ready is low.
        vecs.push_back(mk("bp_first",    1, 1, 1, 4'b1111, 32'h00000000, 16'h0000, 4'b0001, 0, 0, 4'b0000));
        vecs.push_back(mk("bp_hold",     0, 10, 0, 4'b1111, 32'h00000000, 16'h0000, 4'b0000, 0, 0, 4'b0000));
        vecs.push_back(mk("bp_resume1",  0, 1, 1, 4'b1111, 32'h00000000, 16'h0000, 4'b0010, 0, 0, 4'b0000));
        vecs.push_back(mk("bp_resume2",  0, 1, 1, 4'b1111, 32'h00000000, 16'h0000, 4'b0100, 0, 0, 4'b0000));
        vecs.push_back(mk("bp_starve",   0, 1, 1, 4'b1111, 32'h00000000, 16'h0000, 4'b1000, 0, 0, 4'b1000));

        drive(1'b0, 4'b0000, 32'h0, 16'h0);
        #12;
        reset_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            for (int r = 0; r < vecs[n].reps; r++) begin
                @(negedge clk);
                if (vecs[n].do_rst && r == 0) pulse_reset();
                drive(vecs[n].ready, vecs[n].reqs, vecs[n].ts, vecs[n].len);
                #2;
                check_outputs($sformatf("%s[%0d]", vecs[n].name, r), vecs[n].exp_grants,
                              vecs[n].exp_locked, vecs[n].exp_owner, vecs[n].exp_starved);
            end
        end

        // Reset mid-lock: input 2 header with len 5, then async reset during the body.
        @(negedge clk);
        pulse_reset();
        drive(1'b1, 4'b0100, 32'h00000000, 16'h0500);
        #2;
        check_outputs("rml_hdr", 4'b0100, 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        #2;
        check_outputs("rml_body", 4'b0100, 1'b1, 2'd2, 4'b0000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs("rml_in_reset", 4'b0000, 1'b0, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        check_outputs("rml_reset_edge", 4'b0000, 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 4'b1100, 32'h00000000, 16'h0000);
        #2;
        // Tie between 2 and 3 from rr_ptr=0 picks 2; a stale rr_ptr=3 would pick 3.
        check_outputs("rml_rearb", 4'b0100, 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        #2;
        check_outputs("rml_next", 4'b1000, 1'b0, 2'd0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
